// File: rtl/fsm_3.sv
// ============================================================================
// Module   : fsm_3
// Brief    : Coin vending controller, one-hot credit FSM, item priced at 4.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fsm_3 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] in,
  output logic [1:0] out,
  output logic       out_vld
);

  localparam logic [2:0] C_PRICE  = 3'd4;
  localparam logic [1:0] C_EXACT  = 2'b01;
  localparam logic [1:0] C_CHANGE = 2'b11;

  typedef enum logic [3:0] {
    S0 = 4'b0001,
    S1 = 4'b0010,
    S2 = 4'b0100,
    S3 = 4'b1000
  } state_t;

  state_t     state_c;
  state_t     state_n;
  logic [1:0] w_out_n;
  logic       w_vld_n;
  logic [2:0] w_credit;
  logic [2:0] w_coin;
  logic [2:0] w_sum;
  logic       w_illegal;

  always_comb begin
    w_credit  = 3'd0;
    w_illegal = 1'b0;
    case (state_c)
      S0:      w_credit = 3'd0;
      S1:      w_credit = 3'd1;
      S2:      w_credit = 3'd2;
      S3:      w_credit = 3'd3;
      default: w_illegal = 1'b1;
    endcase
  end

  // Code 3 is an invalid coin and is worth nothing.
  always_comb begin
    w_coin = 3'd0;
    case (in)
      2'd1:    w_coin = 3'd1;
      2'd2:    w_coin = 3'd2;
      default: w_coin = 3'd0;
    endcase
  end

  assign w_sum = w_credit + w_coin;

  always_comb begin
    state_n = S0;
    w_out_n = 2'b00;
    w_vld_n = 1'b0;
    if (!w_illegal) begin
      case (w_sum)
        3'd0: state_n = S0;
        3'd1: state_n = S1;
        3'd2: state_n = S2;
        3'd3: state_n = S3;
        default: begin
          state_n = S0;
          w_vld_n = 1'b1;
          w_out_n = (w_sum == C_PRICE) ? C_EXACT : C_CHANGE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_c <= S0;
      out     <= 2'b00;
      out_vld <= 1'b0;
    end else begin
      state_c <= state_n;
      out     <= w_out_n;
      out_vld <= w_vld_n;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fsm_3.sv
// ============================================================================
// Module   : tb_fsm_3
// Brief    : Self-checking bench for fsm_3 against a credit-counting model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fsm_3;

  logic       clk;
  logic       rst;
  logic [1:0] in;
  logic [1:0] out;
  logic       out_vld;

  int n_chk  = 0;
  int n_fail = 0;

  int         m_credit = 0;
  logic [1:0] m_out    = 2'b00;
  logic       m_vld    = 1'b0;

  fsm_3 dut (
    .clk     (clk),
    .rst     (rst),
    .in      (in),
    .out     (out),
    .out_vld (out_vld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of stimulus, advance the model, then check all outputs.
  task automatic step(input logic [1:0] coin, input logic r, input string tag);
    int         value;
    int         total;
    logic [3:0] exp_state;
    @(negedge clk);
    in  = coin;
    rst = r;
    @(posedge clk);
    if (r) begin
      m_credit = 0;
      m_out    = 2'b00;
      m_vld    = 1'b0;
    end else begin
      value = (coin == 2'd1) ? 1 : (coin == 2'd2) ? 2 : 0;
      total = m_credit + value;
      if (total >= 4) begin
        m_vld    = 1'b1;
        m_out    = (total == 5) ? 2'b11 : 2'b01;
        m_credit = 0;
      end else begin
        m_vld    = 1'b0;
        m_out    = 2'b00;
        m_credit = total;
      end
    end
    exp_state = 4'b0001 << m_credit;
    #1;
    chk({tag, ".state"}, dut.state_c, exp_state);
    chk({tag, ".out"},   {2'b00, out}, {2'b00, m_out});
    chk({tag, ".vld"},   {3'b000, out_vld}, {3'b000, m_vld});
  endtask

  task automatic coins(input logic [1:0] a, input logic [1:0] b,
                       input logic [1:0] c, input logic [1:0] d, input string tag);
    logic [1:0] seq [4];
    seq[0] = a; seq[1] = b; seq[2] = c; seq[3] = d;
    for (int i = 0; i < 4; i++) begin
      if (seq[i] != 2'd0) begin
        step(seq[i], 1'b0, tag);
        step(2'd0, 1'b0, tag);
      end
    end
  endtask

  initial begin
    in  = 2'd0;
    rst = 1'b1;
    for (int i = 0; i < 20; i++) step(2'd0, 1'b1, "reset");
    step(2'd0, 1'b0, "release");

    coins(2'd1, 2'd1, 2'd1, 2'd1, "c1111");
    coins(2'd1, 2'd1, 2'd1, 2'd2, "c1112");
    coins(2'd1, 2'd1, 2'd2, 2'd0, "c112");
    coins(2'd2, 2'd2, 2'd0, 2'd0, "c22");
    coins(2'd1, 2'd2, 2'd2, 2'd0, "c122");

    // Invalid coin in S2 is ignored.
    step(2'd2, 1'b0, "inv");
    step(2'd3, 1'b0, "inv");
    step(2'd3, 1'b0, "inv");
    step(2'd2, 1'b0, "inv");

    // Reset beats a completing coin in S3.
    step(2'd1, 1'b0, "rstS3");
    step(2'd2, 1'b0, "rstS3");
    step(2'd2, 1'b1, "rstS3");
    step(2'd0, 1'b0, "rstS3");

    // Coin sampled while out_vld is high starts the next transaction.
    step(2'd2, 1'b0, "b2b");
    step(2'd2, 1'b0, "b2b");
    step(2'd2, 1'b0, "b2b");
    step(2'd2, 1'b0, "b2b");
    step(2'd1, 1'b0, "b2b");
    step(2'd1, 1'b0, "b2b");
    step(2'd2, 1'b0, "b2b");

    // Held coin counts once per cycle.
    step(2'd1, 1'b0, "hold");
    step(2'd1, 1'b0, "hold");
    step(2'd1, 1'b0, "hold");
    step(2'd1, 1'b0, "hold");
    step(2'd1, 1'b0, "hold");

    for (int i = 0; i < 400; i++)
      step(2'($urandom_range(0, 3)), ($urandom_range(0, 31) == 0), "rand");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fsm_3.md
Name: fsm_3

Overview:
- Coin-operated vending controller for a single item priced at 4 units.
- Accepts 1-unit and 2-unit coins, one per clock cycle, and tracks the accumulated credit in a one-hot state machine.
- When the credit reaches 4 it issues a one-cycle vend pulse; when the credit reaches 5 it also issues a 1-unit change flag.
- Sits between the coin-acceptor front end and the dispenser/change actuator logic.

Parameters:
- none (state encoding is fixed; see Behaviour)

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous reset, active-high.
- in  input  2  coin input, sampled every rising edge:
  - 2'd0 = no coin
  - 2'd1 = 1-unit coin
  - 2'd2 = 2-unit coin
  - 2'd3 = invalid, treated as no coin
- out  output  2  vend result, valid only while out_vld=1:
  - bit0 = dispense item
  - bit1 = return 1-unit change
  - 2'b01 = vend, exact payment
  - 2'b11 = vend plus change
  - 2'b00 whenever out_vld=0
- out_vld  output  1  one-cycle pulse marking a completed purchase.

Behaviour:
- State register: 4-bit one-hot, named state_c. Next-state signal is state_n.
  - S0 = 4'b0001: credit 0
  - S1 = 4'b0010: credit 1
  - S2 = 4'b0100: credit 2
  - S3 = 4'b1000: credit 3
- Reset: when rst=1 at a rising edge:
  - state_c <= S0
  - out <= 2'b00
  - out_vld <= 0
  - Reset has priority over any coin presented in the same cycle.
  - Reset mid-transaction discards the accumulated credit and issues no vend or change.
- Transitions on each rising edge with rst=0 (c = coin value; no coin or invalid coin means c=0):
  - Compute new credit = credit(state_c) + c.
  - new credit < 4: state_c <= state with that credit; out_vld <= 0; out <= 0.
  - new credit = 4: state_c <= S0; out_vld <= 1; out <= 2'b01.
  - new credit = 5: state_c <= S0; out_vld <= 1; out <= 2'b11.
  - The maximum reachable credit is 5 (S3 plus a 2-unit coin), so no other case exists.
- Latency and pulse shape:
  - out and out_vld are registered.
  - They assert in the cycle immediately after the edge that samples the completing coin.
  - They deassert on the next edge unless another completing coin is sampled on that edge.
  - A new transaction may begin in the same cycle that out_vld is high, because the state is already S0.
- Coin handling:
  - No coin (in=0) holds the current state indefinitely; there is no timeout.
  - A coin held on in for N consecutive cycles counts as N coins; the upstream block supplies one-cycle pulses.
- Illegal state: any non-one-hot value of state_c returns to S0 on the next edge, with out_vld=0.
- Implementation: the three-process style (state register, combinational next state, registered outputs) is acceptable.

Test Plan:
- Reset: hold rst=1 for 20 cycles with in=0, then release → state_c=S0, out=00, out_vld=0 throughout.
- Coins 1,1,1,1, each a one-cycle pulse separated by one idle cycle → S1, S2, S3, then S0 with out_vld=1 and out=2'b01 for exactly one cycle.
- Coins 1,1,1,2 → S1, S2, S3, then S0 with out_vld=1 and out=2'b11 for one cycle.
- Coins 1,1,2 → S1, S2, then S0 with out=2'b01 and out_vld pulse. Coins 2,2 → S2, then S0 with out=2'b01 and out_vld pulse.
- Coins 1,2,2 → S1, S3, then S0 with out=2'b11 and out_vld pulse. Coin 2 in S3 (credit 5) → change flag asserted.
- Edge cases:
  - in=3 in S2 → stays S2, no pulse.
  - rst=1 while in S3 with in=2 → S0, no pulse.
  - Back-to-back: coin 2 presented in the cycle out_vld is high → next state S2.
